// File: rtl/hf_spi_cfg_rx.sv
// SPI command receiver: oversamples spck/mosi/ncs in pck0 and decodes 16-bit config frames.
// Optional readback of {conf_word, divisor} on miso: define HF_SPI_CFG_READBACK_EN.
module hf_spi_cfg_rx #(
    parameter logic [7:0] CONF_RESET = 8'hE0,
    parameter logic [7:0] DIV_RESET  = 8'd95,
    parameter int         FRAME_BITS = 16
) (
    input  logic       pck0,
    input  logic       nreset,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    output logic       miso,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       cfg_stb,
    output logic       div_stb,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t      state, next_state;
    logic [2:0]  spck_s;
    logic [1:0]  mosi_s;
    logic [2:0]  ncs_s;
    logic        primed, armed;
    logic [15:0] sr;
    logic [4:0]  bit_cnt;

    logic spck_rise, ncs_rise, ncs_fall;
    logic start, do_shift, cfg_hit, div_hit, err_hit;

    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            spck_s <= 3'b000;
            mosi_s <= 2'b00;
            ncs_s  <= 3'b111;
        end else begin
            spck_s <= {spck_s[1:0], spck};
            mosi_s <= {mosi_s[0], mosi};
            ncs_s  <= {ncs_s[1:0], ncs};
        end
    end

    assign spck_rise = spck_s[1] & ~spck_s[2];
    assign ncs_rise  = ncs_s[1] & ~ncs_s[2];
    assign ncs_fall  = ~ncs_s[1] & ncs_s[2];

    // The ncs preset of 1 would fake a falling edge if reset drops while ncs is low;
    // arm only once a genuinely sampled high level has been seen.
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            primed <= 1'b1;
            armed  <= armed | (primed & ncs_s[0]);
        end
    end

    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        do_shift   = 1'b0;
        cfg_hit    = 1'b0;
        div_hit    = 1'b0;
        err_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall && armed) begin
                    start      = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) next_state = CHECK;
                else if (spck_rise && !ncs_s[1]) do_shift = 1'b1;
            end
            CHECK: begin
                next_state = IDLE;
                if (bit_cnt == 5'(FRAME_BITS) && sr[15:12] == 4'b0001)      cfg_hit = 1'b1;
                else if (bit_cnt == 5'(FRAME_BITS) && sr[15:12] == 4'b0010) div_hit = 1'b1;
                else                                                        err_hit = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            sr      <= 16'h0000;
            bit_cnt <= 5'd0;
        end else if (start) begin
            sr      <= 16'h0000;
            bit_cnt <= 5'd0;
        end else if (do_shift) begin
            sr      <= {sr[14:0], mosi_s[1]};
            bit_cnt <= (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            conf_word <= CONF_RESET;
            divisor   <= DIV_RESET;
            cfg_stb   <= 1'b0;
            div_stb   <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            cfg_stb   <= cfg_hit;
            div_stb   <= div_hit;
            frame_err <= err_hit;
            if (cfg_hit) conf_word <= sr[7:0];
            if (div_hit) divisor   <= sr[7:0];
            if (err_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef HF_SPI_CFG_READBACK_EN
    logic [15:0] tx_reg;
    logic        spck_fall;

    assign spck_fall = ~spck_s[1] & spck_s[2];

    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset)                                          tx_reg <= 16'h0000;
        else if (start)                                       tx_reg <= {conf_word, divisor};
        else if (state == SHIFT && spck_fall && !ncs_s[1])   tx_reg <= {tx_reg[14:0], 1'b0};
    end

    assign miso = (state == SHIFT) & tx_reg[15];
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_hf_spi_cfg_rx.sv
// Scoreboard bench for hf_spi_cfg_rx: frames are driven bit-by-bit, expected strobes queued and
// compared by a monitor when the DUT pulses cfg_stb/div_stb/frame_err.
module tb_hf_spi_cfg_rx;

    logic       pck0 = 1'b0;
    logic       nreset = 1'b0;
    logic       spck = 1'b0;
    logic       mosi = 1'b0;
    logic       ncs = 1'b1;
    logic       miso;
    logic [7:0] conf_word, divisor, err_cnt;
    logic       cfg_stb, div_stb, frame_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] kind;   // {cfg_stb, div_stb, frame_err}
        logic [7:0] conf;
        logic [7:0] div;
        logic [7:0] errc;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] m_conf, m_div, m_err;

    hf_spi_cfg_rx dut (
        .pck0(pck0), .nreset(nreset), .spck(spck), .mosi(mosi), .ncs(ncs),
        .miso(miso), .conf_word(conf_word), .divisor(divisor),
        .cfg_stb(cfg_stb), .div_stb(div_stb), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 pck0 = ~pck0;

    task automatic cyc(input int n);
        repeat (n) @(posedge pck0);
        #1;
    endtask

    task automatic model_reset();
        m_conf = 8'hE0;
        m_div  = 8'd95;
        m_err  = 8'd0;
    endtask

    // Pushes the expected outcome, then drives n bits of val MSB-first at spck = pck0/8.
    task automatic send_frame(input logic [31:0] val, input int n, input int gap,
                              output logic [15:0] rb);
        exp_t e;
        logic [15:0] v16;
        v16 = val[15:0];
        if (n == 16 && v16[15:12] == 4'b0001) begin
            m_conf = v16[7:0];
            e.kind = 3'b100;
        end else if (n == 16 && v16[15:12] == 4'b0010) begin
            m_div  = v16[7:0];
            e.kind = 3'b010;
        end else begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            e.kind = 3'b001;
        end
        e.conf = m_conf;
        e.div  = m_div;
        e.errc = m_err;
        exp_q.push_back(e);
        rb = 16'h0;
        ncs = 1'b0;
        cyc(4);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            cyc(4);
            spck = 1'b1;
            rb = {rb[14:0], miso};
            cyc(4);
            spck = 1'b0;
        end
        cyc(4);
        ncs = 1'b1;
        cyc(gap);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            cyc(1);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected strobes never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge pck0) begin
        exp_t it;
        if (nreset && (cfg_stb || div_stb || frame_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got cfg/div/err=%b%b%b, none required",
                         cfg_stb, div_stb, frame_err);
            end else begin
                it = exp_q.pop_front();
                if ({cfg_stb, div_stb, frame_err} !== it.kind || conf_word !== it.conf ||
                    divisor !== it.div || err_cnt !== it.errc) begin
                    failures++;
                    $display("FAIL strobe: got kind=%b conf=%h div=%h err=%0d, required kind=%b conf=%h div=%h err=%0d",
                             {cfg_stb, div_stb, frame_err}, conf_word, divisor, err_cnt,
                             it.kind, it.conf, it.div, it.errc);
                end
            end
        end
    end

    task automatic check_regs(input string name);
        checks++;
        if (conf_word !== m_conf || divisor !== m_div || err_cnt !== m_err) begin
            failures++;
            $display("FAIL %s: got conf=%h div=%h err=%0d, required conf=%h div=%h err=%0d",
                     name, conf_word, divisor, err_cnt, m_conf, m_div, m_err);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        model_reset();
        cyc(3);
        checks++;
        if (conf_word !== 8'hE0) begin
            failures++; $display("FAIL reset_conf: got %h, required e0", conf_word);
        end
        checks++;
        if (divisor !== 8'd95) begin
            failures++; $display("FAIL reset_div: got %0d, required 95", divisor);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++; $display("FAIL reset_err: got %0d, required 0", err_cnt);
        end
        checks++;
        if ({cfg_stb, div_stb, frame_err, miso} !== 4'b0000) begin
            failures++; $display("FAIL reset_outs: got %b, required 0000",
                                 {cfg_stb, div_stb, frame_err, miso});
        end
        nreset = 1'b1;
        cyc(4);
        check_regs("reset_hold");
    endtask

    task automatic test_cfg();
        logic [15:0] rb;
        send_frame(32'h1023, 16, 6, rb);
        drain("cfg");
        check_regs("cfg_regs");
`ifndef HF_SPI_CFG_READBACK_EN
        checks++;
        if (rb !== 16'h0000) begin
            failures++; $display("FAIL miso_tied: got %h, required 0000", rb);
        end
`endif
    endtask

    task automatic test_div();
        logic [15:0] rb;
        send_frame(32'h2040, 16, 6, rb);
        drain("div");
        check_regs("div_regs");
    endtask

    task automatic test_length_err();
        logic [15:0] rb;
        send_frame(32'h1055 >> 1, 15, 6, rb);
        send_frame(32'h1055 << 1, 17, 6, rb);
        send_frame(32'h3011, 16, 6, rb);
        drain("length_err");
        check_regs("length_err_regs");
        checks++;
        if (err_cnt !== 8'd3) begin
            failures++; $display("FAIL err_cnt3: got %0d, required 3", err_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] rb;
        ncs = 1'b0;
        cyc(4);
        for (int i = 7; i >= 0; i--) begin
            mosi = 1'b1;
            cyc(4);
            spck = 1'b1;
            cyc(4);
            spck = 1'b0;
        end
        nreset = 1'b0;
        model_reset();
        cyc(2);
        nreset = 1'b1;
        cyc(4);
        for (int i = 7; i >= 0; i--) begin
            cyc(4);
            spck = 1'b1;
            cyc(4);
            spck = 1'b0;
        end
        cyc(4);
        ncs = 1'b1;
        cyc(12);
        check_regs("midframe_no_decode");
        send_frame(32'h10A1, 16, 6, rb);
        drain("midframe_next");
        check_regs("midframe_next_regs");
    endtask

    task automatic test_back_to_back();
        logic [15:0] rb;
        send_frame(32'h1077, 16, 4, rb);
        send_frame(32'h2088, 16, 6, rb);
        drain("b2b");
        check_regs("b2b_regs");
    endtask

`ifdef HF_SPI_CFG_READBACK_EN
    task automatic test_readback();
        logic [15:0] rb;
        send_frame(32'h1023, 16, 6, rb);
        send_frame(32'h2040, 16, 6, rb);
        send_frame(32'h1055, 16, 6, rb);
        drain("readback");
        checks++;
        if (rb !== 16'h2340) begin
            failures++; $display("FAIL readback_bits: got %h, required 2340", rb);
        end
        check_regs("readback_regs");
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_cfg();
        test_div();
        test_length_err();
        test_reset_midframe();
        test_back_to_back();
`ifdef HF_SPI_CFG_READBACK_EN
        test_readback();
`endif
        cyc(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hf_spi_cfg_rx.md
Name: hf_spi_cfg_rx

Overview:
- Synchronous SPI command receiver for the HF FPGA image.
- Oversamples the ARM's spck/mosi/ncs in the pck0 domain and decodes 16-bit command frames.
- Publishes the 8-bit configuration word consumed by the major-mode muxes (major_mode = conf_word[7:5]), plus a divisor register.
- Replaces the posedge-ncs/posedge-spck capture with a single-clock, glitch-checked, length-validated path.

Parameters:
- CONF_RESET, 8'hE0, conf_word value after reset (major mode 111, everything off).
- DIV_RESET, 8'd95, divisor value after reset.
- FRAME_BITS, 16, required number of spck rising edges per valid frame.

Ports:
- pck0  input  1  system clock; all logic on its rising edge.
- nreset  input  1  asynchronous, active-low reset.
- spck  input  1  SPI clock from ARM, asynchronous to pck0, max pck0/8.
- mosi  input  1  SPI data from ARM, MSB first.
- ncs  input  1  SPI chip select, active low, asynchronous.
- miso  output  1  SPI readback data (see Optional Feature).
- conf_word  output  8  current configuration word.
- divisor  output  8  current divisor register.
- cfg_stb  output  1  one-cycle pulse when conf_word is updated.
- div_stb  output  1  one-cycle pulse when divisor is updated.
- frame_err  output  1  one-cycle pulse on a rejected frame.
- err_cnt  output  8  saturating count of rejected frames.

Behaviour:
- Reset and clocking: one clock, pck0; reset is asynchronous, active-low, named nreset.
- Reset values: conf_word=CONF_RESET, divisor=DIV_RESET, cfg_stb=div_stb=frame_err=0, err_cnt=0, miso=0, state=IDLE, synchronizers preset to idle levels (spck 0, mosi 0, ncs 1).
- Synchronizers: 2-flop synchronizer on each of spck, mosi, ncs. A third spck flop provides edge detection: rise = s2 & ~s3, fall = ~s2 & s3.
- Pin-to-sample latency: 2-3 pck0 cycles.
- FSM states: IDLE, SHIFT, CHECK.
- IDLE:
  - sr and bit_cnt cleared on exit.
  - Go to SHIFT on ncs_s falling edge.
  - If reset is released while ncs is low, stay in IDLE until ncs is high and then falls again; a partial frame is never decoded.
- SHIFT:
  - On spck rise with ncs_s low: sr <= {sr[14:0], mosi_s}; bit_cnt (5-bit) increments, saturating at 31.
  - On ncs_s rising edge: go to CHECK.
  - If an spck rise and an ncs_s rise occur in the same cycle, ncs wins and that edge is not shifted.
- CHECK (exactly 1 cycle), then IDLE:
  - If bit_cnt==FRAME_BITS and sr[15:12]==4'b0001: conf_word<=sr[7:0], cfg_stb=1.
  - Else if bit_cnt==FRAME_BITS and sr[15:12]==4'b0010: divisor<=sr[7:0], div_stb=1.
  - Otherwise (bit_cnt!=FRAME_BITS, or unknown command): no register change, frame_err=1, err_cnt increments, saturating at 255.
  - sr[11:8] is ignored.
- Strobe timing: strobes assert in the cycle after CHECK is entered, aligned with the new register value. Registers hold until the next valid frame.
- Latency: ncs pin rising to conf_word update is at most 4 pck0 cycles.
- Back-to-back frames: ncs high for at least 3 pck0 cycles between frames. A shorter gap may be missed; the next frame is then counted as one long frame and rejected.

Optional Feature:
- Macro: HF_SPI_CFG_READBACK_EN.
- When defined:
  - On IDLE->SHIFT, tx_reg <= {conf_word, divisor}.
  - miso = tx_reg[15] while in SHIFT; tx_reg shifts left on each spck fall with ncs_s low.
  - miso=0 outside SHIFT.
  - The ARM sees the old values MSB-first, delayed by the synchronizer latency; the ARM samples on spck rising.
- When undefined: miso tied 1'b0; no tx_reg.

Test Plan:
- Reset -> conf_word=8'hE0, divisor=8'd95, err_cnt=0, all strobes 0.
- Frame 16'h1023 (16 bits, spck=pck0/8) -> conf_word=8'h23, one cfg_stb pulse, divisor unchanged, frame_err 0.
- Frame 16'h2040 -> divisor=8'h40, one div_stb pulse, conf_word unchanged.
- 15-bit frame, then 17-bit frame, then 16-bit frame 16'h3011 -> three frame_err pulses, err_cnt=3, conf_word unchanged.
- nreset pulsed low mid-frame after 8 bits with ncs still low; ncs then rises -> no decode, no frame_err, registers at reset values. Next clean frame 16'h10A1 -> conf_word=8'hA1.
- HF_SPI_CFG_READBACK_EN defined, conf_word=8'h23, divisor=8'h40, frame 16'h1055 -> miso bits 16'h2340 MSB-first, then conf_word=8'h55.
